// File: rtl/irq_dispatch.sv
// irq_dispatch: interrupt initiator for the frontend irqload/irqnum pair.
// Latches 16 sources as pending and applies a mask. A round-robin pick is issued
// as a one-cycle irqload strobe. After the core's ack, a hold-off gap follows.
// Optional feature: define IRQ_TIMEOUT_EN to enable ack timeout, reissue and drop.
// Without it, WAIT_ACK waits forever and dropped is tied low.

module irq_dispatch #(
  parameter int HOLDOFF   = 8,
  parameter int TIMEOUT   = 64,
  parameter int MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] irq_src,
  input  logic [15:0] irq_edge,
  input  logic        mask_wr,
  input  logic [15:0] mask_data,
  input  logic        irq_ack,
  output logic        irqload,
  output logic [3:0]  irqnum,
  output logic [15:0] pending,
  output logic        busy,
  output logic        dropped
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_HOLDOFF
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] src_q;
  logic [15:0] src_qq;
  logic [15:0] mask;
  logic [15:0] pend_m;
  logic [15:0] rise;
  logic [15:0] clr_mask;
  logic [3:0]  rr_ptr;
  logic [3:0]  sel;
  logic [3:0]  idx;
  logic        found;
  logic [7:0]  hold_cnt;

  logic        do_issue;
  logic        do_retry;
  logic        do_drop;
  logic        ack_take;
  logic        timeout;
  logic        retry_exhausted;

  // Edge detection works on the sampled copy. A new edge and a level line
  // therefore both reach the pending register one edge after src_q captures them.
  assign rise = src_q & ~src_qq;

  // Round-robin pick: the first enabled pending bit at or above rr_ptr, wrapping 15 to 0.
  always_comb begin
    pend_m = pending & mask;
    sel    = rr_ptr;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < 16; i++) begin
      idx = rr_ptr + 4'(i);
      if (!found && pend_m[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. An ack wins over a timeout in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (found) state_nxt = ST_ISSUE;
      ST_ISSUE:    state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (irq_ack)      state_nxt = ST_HOLDOFF;
        else if (timeout) state_nxt = retry_exhausted ? ST_HOLDOFF : ST_ISSUE;
      end
      ST_HOLDOFF:  if (hold_cnt <= 8'd1) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Control decode: busy, issue/retry/drop strobes and the edge bit to clear on ack or drop.
  always_comb begin
    busy     = (state != ST_IDLE);
    do_issue = (state == ST_IDLE) && found;
    ack_take = (state == ST_WAIT_ACK) && irq_ack;
    do_retry = (state == ST_WAIT_ACK) && !irq_ack && timeout && !retry_exhausted;
    do_drop  = (state == ST_WAIT_ACK) && !irq_ack && timeout && retry_exhausted;
    clr_mask = '0;
    if (ack_take || do_drop) clr_mask = irq_edge & (16'b1 << irqnum);
  end

  // Datapath: sampling, pending/mask registers, issue outputs, rr pointer and hold-off count.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q    <= '0;
      src_qq   <= '0;
      pending  <= '0;
      mask     <= 16'hFFFF;
      irqload  <= 1'b0;
      irqnum   <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
    end else begin
      src_q   <= irq_src;
      src_qq  <= src_q;
      pending <= (irq_edge & ((pending & ~clr_mask) | rise)) | (~irq_edge & src_q);
      if (mask_wr) mask <= mask_data;
      irqload <= do_issue || do_retry;
      if (do_issue) begin
        irqnum <= sel;
        rr_ptr <= sel + 4'd1;
      end
      if (ack_take || do_drop)
        hold_cnt <= 8'(HOLDOFF);
      else if (state == ST_HOLDOFF && hold_cnt != 8'd0)
        hold_cnt <= hold_cnt - 8'd1;
    end
  end

`ifdef IRQ_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic [7:0]  retry_cnt;

  assign timeout         = (to_cnt == 16'(TIMEOUT - 1));
  assign retry_exhausted = (retry_cnt >= 8'(MAX_RETRY));

  // Ack timeout and retry tracking. The wait counter restarts on every entry into WAIT_ACK.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt    <= '0;
      retry_cnt <= '0;
      dropped   <= 1'b0;
    end else begin
      dropped <= do_drop;
      if (state != ST_WAIT_ACK || timeout) to_cnt <= '0;
      else                                 to_cnt <= to_cnt + 16'd1;
      if (do_issue || ack_take) retry_cnt <= '0;
      else if (do_retry)        retry_cnt <= retry_cnt + 8'd1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout            = 1'b0;
  assign retry_exhausted    = 1'b0;
  assign dropped            = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT > 0) && (MAX_RETRY > 0);
`endif

endmodule

// File: tb/tb_irq_dispatch.sv
// Directed self-checking bench for irq_dispatch (HOLDOFF=8, TIMEOUT=64, MAX_RETRY=3).
// Inputs change 1 time unit after a rising edge, and outputs are sampled at that same point.

module tb_irq_dispatch;

  logic        clk;
  logic        rst;
  logic [15:0] irq_src;
  logic [15:0] irq_edge;
  logic        mask_wr;
  logic [15:0] mask_data;
  logic        irq_ack;
  logic        irqload;
  logic [3:0]  irqnum;
  logic [15:0] pending;
  logic        busy;
  logic        dropped;

  int compared   = 0;
  int mismatched = 0;

  irq_dispatch #(.HOLDOFF(8), .TIMEOUT(64), .MAX_RETRY(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_src   (irq_src),
    .irq_edge  (irq_edge),
    .mask_wr   (mask_wr),
    .mask_data (mask_data),
    .irq_ack   (irq_ack),
    .irqload   (irqload),
    .irqnum    (irqnum),
    .pending   (pending),
    .busy      (busy),
    .dropped   (dropped)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] src, input logic ack);
    irq_src = src;
    irq_ack = ack;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    irq_edge  = 16'hFFFF;
    mask_wr   = 1'b0;
    mask_data = 16'h0000;
    applyStimulus(16'h0000, 1'b0);
    tick(2);
    checkOutput("rst_irqload", 32'(irqload), 32'h0);
    checkOutput("rst_irqnum",  32'(irqnum),  32'h0);
    checkOutput("rst_pending", 32'(pending), 32'h0);
    checkOutput("rst_busy",    32'(busy),    32'h0);
    checkOutput("rst_dropped", 32'(dropped), 32'h0);

    // Single edge source 5: pending at E1, irqload at E2, ack at E5, idle 8 cycles later.
    $display("[TB] single edge source 5");
    rst = 1'b0;
    applyStimulus(16'h0020, 1'b0);
    tick(1);
    checkOutput("e0_pending", 32'(pending), 32'h0);
    tick(1);
    checkOutput("e1_pending", 32'(pending), 32'h0020);
    checkOutput("e1_irqload", 32'(irqload), 32'h0);
    tick(1);
    checkOutput("e2_irqload", 32'(irqload), 32'h1);
    checkOutput("e2_irqnum",  32'(irqnum),  32'h5);
    checkOutput("e2_busy",    32'(busy),    32'h1);
    tick(1);
    checkOutput("e3_irqload", 32'(irqload), 32'h0);
    checkOutput("e3_irqnum",  32'(irqnum),  32'h5);
    checkOutput("e3_busy",    32'(busy),    32'h1);
    tick(1);
    applyStimulus(16'h0020, 1'b1);
    tick(1);
    checkOutput("e5_pending", 32'(pending), 32'h0);
    checkOutput("e5_busy",    32'(busy),    32'h1);
    applyStimulus(16'h0020, 1'b0);
    tick(7);
    checkOutput("e12_busy", 32'(busy), 32'h1);
    tick(1);
    checkOutput("e13_busy",    32'(busy),    32'h0);
    checkOutput("e13_irqload", 32'(irqload), 32'h0);

    // Round-robin between 2 and 9 from rr_ptr=0, then 2 re-raised while 9 waits.
    $display("[TB] round robin 2/9");
    rst = 1'b1;
    applyStimulus(16'h0000, 1'b0);
    tick(2);
    rst = 1'b0;
    applyStimulus(16'h0204, 1'b0);
    tick(3);
    checkOutput("rr1_irqload", 32'(irqload), 32'h1);
    checkOutput("rr1_irqnum",  32'(irqnum),  32'h2);
    tick(1);
    applyStimulus(16'h0204, 1'b1);
    tick(1);
    checkOutput("rr1_ack_pending", 32'(pending), 32'h0200);
    applyStimulus(16'h0200, 1'b0);
    tick(1);
    applyStimulus(16'h0204, 1'b0);
    tick(2);
    checkOutput("rr_repend", 32'(pending), 32'h0204);
    tick(5);
    checkOutput("rr_gap_busy",    32'(busy),    32'h0);
    checkOutput("rr_gap_irqload", 32'(irqload), 32'h0);
    tick(1);
    checkOutput("rr2_irqload", 32'(irqload), 32'h1);
    checkOutput("rr2_irqnum",  32'(irqnum),  32'h9);
    applyStimulus(16'h0204, 1'b1);
    tick(1);
    checkOutput("ack_in_issue_pending", 32'(pending), 32'h0204);
    checkOutput("ack_in_issue_busy",    32'(busy),    32'h1);
    tick(1);
    checkOutput("rr2_ack_pending", 32'(pending), 32'h0004);
    applyStimulus(16'h0204, 1'b0);
    tick(8);
    checkOutput("rr2_idle_busy", 32'(busy), 32'h0);
    tick(1);
    checkOutput("rr3_irqload", 32'(irqload), 32'h1);
    checkOutput("rr3_irqnum",  32'(irqnum),  32'h2);
    tick(1);
    applyStimulus(16'h0204, 1'b1);
    tick(1);
    checkOutput("rr3_ack_pending", 32'(pending), 32'h0);
    applyStimulus(16'h0204, 1'b0);
    tick(8);
    checkOutput("rr3_idle_busy", 32'(busy), 32'h0);

    // Masked source 5 stays pending without issue until the mask is reopened.
    $display("[TB] mask");
    applyStimulus(16'h0000, 1'b0);
    mask_wr   = 1'b1;
    mask_data = 16'hFFDF;
    tick(1);
    mask_wr = 1'b0;
    tick(1);
    applyStimulus(16'h0020, 1'b0);
    tick(3);
    checkOutput("mask_pending", 32'(pending), 32'h0020);
    checkOutput("mask_irqload", 32'(irqload), 32'h0);
    checkOutput("mask_busy",    32'(busy),    32'h0);
    tick(2);
    checkOutput("mask_irqload_late", 32'(irqload), 32'h0);
    mask_wr   = 1'b1;
    mask_data = 16'hFFFF;
    tick(1);
    mask_wr = 1'b0;
    checkOutput("unmask_irqload_w", 32'(irqload), 32'h0);
    tick(1);
    checkOutput("unmask_irqload", 32'(irqload), 32'h1);
    checkOutput("unmask_irqnum",  32'(irqnum),  32'h5);
    tick(1);
    applyStimulus(16'h0020, 1'b1);
    tick(1);
    checkOutput("unmask_ack_pending", 32'(pending), 32'h0);
    applyStimulus(16'h0020, 1'b0);
    tick(8);
    checkOutput("unmask_idle_busy", 32'(busy), 32'h0);

    // Level line 7 held through the ack reissues HOLDOFF+1 cycles later; dropped before the ack it does not.
    $display("[TB] level line 7");
    irq_edge = 16'hFF7F;
    applyStimulus(16'h0080, 1'b0);
    tick(3);
    checkOutput("lvl1_irqload", 32'(irqload), 32'h1);
    checkOutput("lvl1_irqnum",  32'(irqnum),  32'h7);
    tick(1);
    applyStimulus(16'h0080, 1'b1);
    tick(1);
    checkOutput("lvl_ack_pending", 32'(pending), 32'h0080);
    applyStimulus(16'h0080, 1'b0);
    tick(8);
    checkOutput("lvl_gap_busy",    32'(busy),    32'h0);
    checkOutput("lvl_gap_irqload", 32'(irqload), 32'h0);
    tick(1);
    checkOutput("lvl2_irqload", 32'(irqload), 32'h1);
    checkOutput("lvl2_irqnum",  32'(irqnum),  32'h7);
    tick(1);
    applyStimulus(16'h0000, 1'b0);
    tick(2);
    checkOutput("lvl_drop_pending", 32'(pending), 32'h0);
    checkOutput("lvl_drop_busy",    32'(busy),    32'h1);
    applyStimulus(16'h0000, 1'b1);
    tick(1);
    applyStimulus(16'h0000, 1'b0);
    tick(8);
    checkOutput("lvl_end_busy", 32'(busy), 32'h0);
    tick(1);
    checkOutput("lvl_noreissue_irqload", 32'(irqload), 32'h0);
    checkOutput("lvl_noreissue_busy",    32'(busy),    32'h0);

    // Reset during WAIT_ACK on source 3, masked and deasserted while waiting.
    $display("[TB] reset in wait_ack");
    irq_edge = 16'hFFFF;
    applyStimulus(16'h0008, 1'b0);
    tick(3);
    checkOutput("w3_irqload", 32'(irqload), 32'h1);
    checkOutput("w3_irqnum",  32'(irqnum),  32'h3);
    tick(1);
    mask_wr   = 1'b1;
    mask_data = 16'hFFF7;
    tick(1);
    mask_wr = 1'b0;
    applyStimulus(16'h0000, 1'b0);
    tick(1);
    checkOutput("w3_hold_busy",    32'(busy),    32'h1);
    checkOutput("w3_hold_irqnum",  32'(irqnum),  32'h3);
    checkOutput("w3_hold_pending", 32'(pending), 32'h0008);
    rst = 1'b1;
    tick(1);
    checkOutput("w3_rst_irqload", 32'(irqload), 32'h0);
    checkOutput("w3_rst_irqnum",  32'(irqnum),  32'h0);
    checkOutput("w3_rst_pending", 32'(pending), 32'h0);
    checkOutput("w3_rst_busy",    32'(busy),    32'h0);
    rst = 1'b0;
    applyStimulus(16'h0000, 1'b1);
    tick(1);
    checkOutput("w3_lateack_busy",    32'(busy),    32'h0);
    checkOutput("w3_lateack_irqload", 32'(irqload), 32'h0);
    tick(1);
    checkOutput("w3_lateack_busy2", 32'(busy),    32'h0);
    checkOutput("w3_lateack_pend2", 32'(pending), 32'h0);
    applyStimulus(16'h0000, 1'b0);

    // Source 4 never acked.
    $display("[TB] no ack on source 4");
    applyStimulus(16'h0010, 1'b0);
    tick(3);
    checkOutput("na_irqload1", 32'(irqload), 32'h1);
    checkOutput("na_irqnum1",  32'(irqnum),  32'h4);
`ifdef IRQ_TIMEOUT_EN
    for (int p = 2; p <= 4; p++) begin
      tick(64);
      checkOutput("to_gap_irqload", 32'(irqload), 32'h0);
      tick(1);
      checkOutput("to_pulse_irqload", 32'(irqload), 32'h1);
      checkOutput("to_pulse_irqnum",  32'(irqnum),  32'h4);
    end
    tick(64);
    checkOutput("to_predrop_dropped", 32'(dropped), 32'h0);
    checkOutput("to_predrop_pending", 32'(pending), 32'h0010);
    tick(1);
    checkOutput("to_drop_dropped", 32'(dropped), 32'h1);
    checkOutput("to_drop_pending", 32'(pending), 32'h0);
    checkOutput("to_drop_irqload", 32'(irqload), 32'h0);
    tick(1);
    checkOutput("to_postdrop_dropped", 32'(dropped), 32'h0);
`else
    tick(100);
    checkOutput("na_busy",    32'(busy),    32'h1);
    checkOutput("na_irqload", 32'(irqload), 32'h0);
    checkOutput("na_dropped", 32'(dropped), 32'h0);
    checkOutput("na_pending", 32'(pending), 32'h0010);
    checkOutput("na_irqnum",  32'(irqnum),  32'h4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
